simd_addsub_pipe: RTL and testbench

Parametrised SIMD add/subtract engine used as an RTL black box beneath HLS-generated control. It packs `LANES` independent unsigned `W`-bit add/sub lanes into one pipeline with a configurable latency. It supports per-transaction op select, optional saturation and per-lane overflow flags. Control follows the ap_ctrl_chain protocol with ap_continue back-pressure, so a downstream stall holds results without losing in-flight transactions.

---
 rtl/simd_pkg.sv | 21 ++
 rtl/simd_addsub_pipe_if.sv | 28 ++
 rtl/simd_lane.sv | 53 +++++
 rtl/simd_addsub_pipe.sv | 72 +++++++
 tb/tb_simd_addsub_pipe.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD add/sub engine: op encoding, lane packing
// and the elaboration-time parameter range check.
`ifndef SIMD_PKG_MACROS
`define SIMD_PKG_MACROS
`define SIMD_RANGE_CHECK(lbl, val, lo, hi) \
  if (((val) < (lo)) || ((val) > (hi))) begin : lbl \
    $error("simd_addsub_pipe: parameter out of range"); \
  end
`endif

package simd_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Lane i occupies [lane_lsb(i, w) +: w] of a packed operand/result bus.
  function automatic int lane_lsb(int lane, int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/simd_addsub_pipe_if.sv
// Handshake and data bundle between HLS control and the SIMD add/sub engine.
interface simd_addsub_pipe_if #(
  parameter int LANES = 4,
  parameter int W     = 10
);
  logic               ap_ce;
  logic               ap_start;
  logic               ap_continue;
  logic               op;
  logic [LANES*W-1:0] a;
  logic [LANES*W-1:0] b;
  logic               ap_ready;
  logic               ap_done;
  logic               ap_idle;
  logic [LANES*W-1:0] z;
  logic               z_ap_vld;
  logic [LANES-1:0]   ovf;

  modport slave (
    input  ap_ce, ap_start, ap_continue, op, a, b,
    output ap_ready, ap_done, ap_idle, z, z_ap_vld, ovf
  );

  modport master (
    output ap_ce, ap_start, ap_continue, op, a, b,
    input  ap_ready, ap_done, ap_idle, z, z_ap_vld, ovf
  );
endinterface

// File: rtl/simd_lane.sv
// One lane: add/sub with carry/borrow, optional saturation, LAT-deep data
// pipe and the held output register.
module simd_lane
  import simd_pkg::*;
#(
  parameter int W   = 10,
  parameter int LAT = 2,
  parameter int SAT = 0
) (
  input  logic         ap_clk,
  input  logic         ap_rst,
  input  logic         adv,
  input  logic         load_out,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] z,
  output logic         ovf
);

  logic [W:0] sum;
  logic [W:0] diff;
  logic [W:0] res;
  logic [W:0] stage_q [LAT];

  // Bit W is carry-out for add and borrow for sub; saturation keys off it.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    res  = (op == OP_ADD) ? sum : diff;
    if ((SAT != 0) && res[W]) begin
      res[W-1:0] = (op == OP_SUB) ? '0 : '1;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int j = 0; j < LAT; j++) stage_q[j] <= '0;
      z   <= '0;
      ovf <= 1'b0;
    end else begin
      if (adv) begin
        stage_q[0] <= res;
        for (int j = 1; j < LAT; j++) stage_q[j] <= stage_q[j-1];
      end
      if (load_out) begin
        z   <= stage_q[LAT-1][W-1:0];
        ovf <= stage_q[LAT-1][W];
      end
    end
  end

endmodule

// File: rtl/simd_addsub_pipe.sv
// SIMD add/sub engine under ap_ctrl_chain control: token pipeline, held
// output with ap_continue back-pressure, and LANES arithmetic lanes.
module simd_addsub_pipe
  import simd_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = 10,
  parameter int LAT   = 2,
  parameter int SAT   = 0
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  simd_addsub_pipe_if.slave  bus
);

  `SIMD_RANGE_CHECK(g_chk_lanes, LANES, 1, 16)
  `SIMD_RANGE_CHECK(g_chk_w, W, 2, 48)
  `SIMD_RANGE_CHECK(g_chk_lat, LAT, 1, 8)
  `SIMD_RANGE_CHECK(g_chk_sat, SAT, 0, 1)

  logic               adv;
  logic               out_full;
  logic               tok_last;
  logic               load_out;
  logic [LAT-1:0]     tok;
  logic [LANES*W-1:0] z_w;
  logic [LANES-1:0]   ovf_w;

  // A full, unacknowledged output freezes every stage, so nothing is dropped.
  assign adv      = bus.ap_ce & (~out_full | bus.ap_continue);
  assign tok_last = tok[LAT-1];
  assign load_out = adv & tok_last;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      tok      <= '0;
      out_full <= 1'b0;
    end else begin
      if (adv) begin
        tok[0] <= bus.ap_start;
        for (int j = 1; j < LAT; j++) tok[j] <= tok[j-1];
      end
      out_full <= (out_full & ~bus.ap_continue) | load_out;
    end
  end

  assign bus.ap_ready = bus.ap_start & adv;
  assign bus.ap_done  = out_full;
  assign bus.z_ap_vld = out_full;
  assign bus.ap_idle  = ~bus.ap_start & ~out_full & ~(|tok);
  assign bus.z        = z_w;
  assign bus.ovf      = ovf_w;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simd_lane #(
      .W   (W),
      .LAT (LAT),
      .SAT (SAT)
    ) u_lane (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .adv      (adv),
      .load_out (load_out),
      .op       (bus.op),
      .a        (bus.a[lane_lsb(i, W) +: W]),
      .b        (bus.b[lane_lsb(i, W) +: W]),
      .z        (z_w[lane_lsb(i, W) +: W]),
      .ovf      (ovf_w[i])
    );
  end

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// Directed bench for simd_addsub_pipe: a wrapping and a saturating instance
// share stimulus; expected values are hand-computed constants.
module tb_simd_addsub_pipe;

  logic ap_clk;
  logic ap_rst;
  int   vecs;
  int   errs;

  simd_addsub_pipe_if #(.LANES(4), .W(10)) bus ();
  simd_addsub_pipe_if #(.LANES(4), .W(10)) bus_s ();

  assign bus_s.ap_ce       = bus.ap_ce;
  assign bus_s.ap_start    = bus.ap_start;
  assign bus_s.ap_continue = bus.ap_continue;
  assign bus_s.op          = bus.op;
  assign bus_s.a           = bus.a;
  assign bus_s.b           = bus.b;

  simd_addsub_pipe #(.LANES(4), .W(10), .LAT(2), .SAT(0)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus.slave)
  );

  simd_addsub_pipe #(.LANES(4), .W(10), .LAT(2), .SAT(1)) dut_s (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus_s.slave)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  function automatic logic [39:0] pk(logic [9:0] l3, logic [9:0] l2, logic [9:0] l1, logic [9:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic cyc();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    bus.ap_ce = 1'b1;
    bus.ap_start = 1'b0;
    bus.ap_continue = 1'b1;
    bus.op = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #12;
    vecs++; if (bus.ap_done !== 1'b0) begin errs++; $display("FAIL rst_done got %b want 0", bus.ap_done); end
    vecs++; if (bus.z_ap_vld !== 1'b0) begin errs++; $display("FAIL rst_vld got %b want 0", bus.z_ap_vld); end
    vecs++; if (bus.z !== 40'h0) begin errs++; $display("FAIL rst_z got %h want 0", bus.z); end
    vecs++; if (bus.ovf !== 4'h0) begin errs++; $display("FAIL rst_ovf got %b want 0", bus.ovf); end
    vecs++; if (bus.ap_idle !== 1'b1) begin errs++; $display("FAIL rst_idle got %b want 1", bus.ap_idle); end
    vecs++; if (bus.ap_ready !== 1'b0) begin errs++; $display("FAIL rst_ready got %b want 0", bus.ap_ready); end
    ap_rst = 1'b0;
    cyc();
  endtask

  task automatic test_add();
    bus.ap_start = 1'b1;
    bus.op = 1'b0;
    bus.a = pk(10'd0, 10'd0, 10'd0, 10'd3);
    bus.b = pk(10'd0, 10'd0, 10'd0, 10'd5);
    #1;
    vecs++; if (bus.ap_ready !== 1'b1) begin errs++; $display("FAIL add_ready got %b want 1", bus.ap_ready); end
    vecs++; if (bus.ap_idle !== 1'b0) begin errs++; $display("FAIL add_idle got %b want 0", bus.ap_idle); end
    cyc();
    bus.ap_start = 1'b0;
    vecs++; if (bus.ap_done !== 1'b0) begin errs++; $display("FAIL add_done_k got %b want 0", bus.ap_done); end
    cyc();
    vecs++; if (bus.ap_done !== 1'b0) begin errs++; $display("FAIL add_done_k1 got %b want 0", bus.ap_done); end
    cyc();
    vecs++; if (bus.ap_done !== 1'b1) begin errs++; $display("FAIL add_done_k2 got %b want 1", bus.ap_done); end
    vecs++; if (bus.z_ap_vld !== 1'b1) begin errs++; $display("FAIL add_vld got %b want 1", bus.z_ap_vld); end
    vecs++; if (bus.z !== pk(10'd0, 10'd0, 10'd0, 10'd8)) begin errs++; $display("FAIL add_z got %h want %h", bus.z, pk(10'd0, 10'd0, 10'd0, 10'd8)); end
    vecs++; if (bus.ovf !== 4'b0000) begin errs++; $display("FAIL add_ovf got %b want 0000", bus.ovf); end
    cyc();
    vecs++; if (bus.ap_done !== 1'b0) begin errs++; $display("FAIL add_pulse got %b want 0", bus.ap_done); end
  endtask

  task automatic test_sub_sat();
    bus.ap_start = 1'b1;
    bus.op = 1'b1;
    bus.a = pk(10'd0, 10'd0, 10'd2, 10'd0);
    bus.b = pk(10'd0, 10'd0, 10'd5, 10'd0);
    cyc();
    bus.ap_start = 1'b0;
    cyc();
    cyc();
    vecs++; if (bus.z !== pk(10'd0, 10'd0, 10'd1021, 10'd0)) begin errs++; $display("FAIL sub_wrap_z got %h want %h", bus.z, pk(10'd0, 10'd0, 10'd1021, 10'd0)); end
    vecs++; if (bus.ovf !== 4'b0010) begin errs++; $display("FAIL sub_wrap_ovf got %b want 0010", bus.ovf); end
    vecs++; if (bus_s.z !== 40'h0) begin errs++; $display("FAIL sub_sat_z got %h want 0", bus_s.z); end
    vecs++; if (bus_s.ovf !== 4'b0010) begin errs++; $display("FAIL sub_sat_ovf got %b want 0010", bus_s.ovf); end
    vecs++; if (bus_s.ap_done !== 1'b1) begin errs++; $display("FAIL sub_sat_done got %b want 1", bus_s.ap_done); end
    bus.ap_start = 1'b1;
    bus.op = 1'b0;
    bus.a = pk(10'd0, 10'd0, 10'd0, 10'd1000);
    bus.b = pk(10'd0, 10'd0, 10'd0, 10'd100);
    cyc();
    bus.ap_start = 1'b0;
    cyc();
    cyc();
    vecs++; if (bus.z !== pk(10'd0, 10'd0, 10'd0, 10'd76)) begin errs++; $display("FAIL addw_z got %h want %h", bus.z, pk(10'd0, 10'd0, 10'd0, 10'd76)); end
    vecs++; if (bus.ovf !== 4'b0001) begin errs++; $display("FAIL addw_ovf got %b want 0001", bus.ovf); end
    vecs++; if (bus_s.z !== pk(10'd0, 10'd0, 10'd0, 10'd1023)) begin errs++; $display("FAIL adds_z got %h want %h", bus_s.z, pk(10'd0, 10'd0, 10'd0, 10'd1023)); end
    vecs++; if (bus_s.ovf !== 4'b0001) begin errs++; $display("FAIL adds_ovf got %b want 0001", bus_s.ovf); end
  endtask

  task automatic test_back_to_back();
    bus.op = 1'b0;
    bus.ap_continue = 1'b1;
    for (int c = 0; c < 12; c++) begin
      int t;
      logic [39:0] ez;
      bus.ap_start = (c < 8);
      bus.a = pk(10'd1020, 10'd0, 10'd0, 10'(10 * c + 1));
      bus.b = pk(10'(c), 10'd0, 10'd0, 10'(c));
      #1;
      if (c < 8) begin
        vecs++; if (bus.ap_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready c=%0d got %b want 1", c, bus.ap_ready); end
      end
      cyc();
      t = c - 2;
      if (c >= 2 && c < 10) begin
        ez = pk(10'(1020 + t), 10'd0, 10'd0, 10'(11 * t + 1));
        vecs++; if (bus.ap_done !== 1'b1) begin errs++; $display("FAIL b2b_done c=%0d got %b want 1", c, bus.ap_done); end
        vecs++; if (bus.z !== ez) begin errs++; $display("FAIL b2b_z t=%0d got %h want %h", t, bus.z, ez); end
        vecs++; if (bus.ovf !== {(t >= 4), 3'b000}) begin errs++; $display("FAIL b2b_ovf t=%0d got %b want %b", t, bus.ovf, {(t >= 4), 3'b000}); end
      end else begin
        vecs++; if (bus.ap_done !== 1'b0) begin errs++; $display("FAIL b2b_idle_done c=%0d got %b want 0", c, bus.ap_done); end
      end
    end
  endtask

  task automatic test_stall();
    int ptr;
    int idx;
    logic pre_ready;
    logic pre_done;
    logic [39:0] ez;
    ptr = 0;
    idx = 0;
    bus.op = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.ap_start = (ptr < 6);
      bus.a = pk(10'd0, 10'd0, 10'(ptr + 1), 10'(100 + ptr));
      bus.b = pk(10'd0, 10'd0, 10'd0, 10'(ptr));
      bus.ap_continue = !(c >= 3 && c < 8);
      #1;
      pre_ready = bus.ap_ready;
      pre_done = bus.ap_done;
      if (pre_done) begin
        ez = pk(10'd0, 10'd0, 10'(idx + 1), 10'(100 + 2 * idx));
        vecs++; if (bus.z !== ez) begin errs++; $display("FAIL stall_z idx=%0d got %h want %h", idx, bus.z, ez); end
      end
      if (c >= 3 && c < 8) begin
        vecs++; if (pre_done !== 1'b1) begin errs++; $display("FAIL stall_hold c=%0d got %b want 1", c, pre_done); end
        vecs++; if (pre_ready !== 1'b0) begin errs++; $display("FAIL stall_ready c=%0d got %b want 0", c, pre_ready); end
      end
      cyc();
      if (pre_ready) ptr++;
      if (pre_done && bus.ap_continue) idx++;
    end
    vecs++; if (ptr !== 6) begin errs++; $display("FAIL stall_accepted got %0d want 6", ptr); end
    vecs++; if (idx !== 6) begin errs++; $display("FAIL stall_delivered got %0d want 6", idx); end
    bus.ap_continue = 1'b1;
  endtask

  task automatic test_ce();
    int pat [4] = '{0, 1, 0, 1};
    bus.ap_ce = 1'b1;
    bus.ap_continue = 1'b1;
    bus.ap_start = 1'b1;
    bus.op = 1'b0;
    bus.a = pk(10'd0, 10'd512, 10'd0, 10'd1023);
    bus.b = pk(10'd0, 10'd511, 10'd0, 10'd1);
    #1;
    vecs++; if (bus.ap_ready !== 1'b1) begin errs++; $display("FAIL ce_ready got %b want 1", bus.ap_ready); end
    cyc();
    bus.ap_start = 1'b0;
    for (int e = 0; e < 4; e++) begin
      bus.ap_ce = (pat[e] != 0);
      cyc();
      vecs++; if (bus.ap_done !== (e == 3)) begin errs++; $display("FAIL ce_done e=%0d got %b want %b", e, bus.ap_done, (e == 3)); end
    end
    vecs++; if (bus.z !== pk(10'd0, 10'd1023, 10'd0, 10'd0)) begin errs++; $display("FAIL ce_z got %h want %h", bus.z, pk(10'd0, 10'd1023, 10'd0, 10'd0)); end
    vecs++; if (bus.ovf !== 4'b0001) begin errs++; $display("FAIL ce_ovf got %b want 0001", bus.ovf); end
    vecs++; if (bus_s.z !== pk(10'd0, 10'd1023, 10'd0, 10'd1023)) begin errs++; $display("FAIL ce_sat_z got %h want %h", bus_s.z, pk(10'd0, 10'd1023, 10'd0, 10'd1023)); end
    bus.ap_ce = 1'b1;
    bus.ap_continue = 1'b0;
    cyc();
    vecs++; if (bus.ap_done !== 1'b1) begin errs++; $display("FAIL ce_hold got %b want 1", bus.ap_done); end
    bus.ap_ce = 1'b0;
    bus.ap_continue = 1'b1;
    bus.ap_start = 1'b1;
    #1;
    vecs++; if (bus.ap_ready !== 1'b0) begin errs++; $display("FAIL ce_low_ready got %b want 0", bus.ap_ready); end
    bus.ap_start = 1'b0;
    cyc();
    vecs++; if (bus.ap_done !== 1'b0) begin errs++; $display("FAIL ce_low_consume got %b want 0", bus.ap_done); end
    vecs++; if (bus.z !== pk(10'd0, 10'd1023, 10'd0, 10'd0)) begin errs++; $display("FAIL ce_low_zhold got %h want %h", bus.z, pk(10'd0, 10'd1023, 10'd0, 10'd0)); end
    bus.ap_ce = 1'b1;
  endtask

  task automatic test_reset_midflight();
    bus.ap_ce = 1'b1;
    bus.ap_continue = 1'b1;
    bus.ap_start = 1'b1;
    bus.op = 1'b0;
    bus.a = pk(10'd1, 10'd2, 10'd3, 10'd4);
    bus.b = pk(10'd1, 10'd1, 10'd1, 10'd1);
    cyc();
    cyc();
    bus.ap_start = 1'b0;
    #3;
    ap_rst = 1'b1;
    #1;
    vecs++; if (bus.z !== 40'h0) begin errs++; $display("FAIL arst_z got %h want 0", bus.z); end
    vecs++; if (bus.ovf !== 4'h0) begin errs++; $display("FAIL arst_ovf got %b want 0", bus.ovf); end
    vecs++; if (bus_s.z !== 40'h0) begin errs++; $display("FAIL arst_sat_z got %h want 0", bus_s.z); end
    vecs++; if (bus.ap_done !== 1'b0) begin errs++; $display("FAIL arst_done got %b want 0", bus.ap_done); end
    vecs++; if (bus.ap_idle !== 1'b1) begin errs++; $display("FAIL arst_idle got %b want 1", bus.ap_idle); end
    @(posedge ap_clk);
    #3;
    ap_rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      vecs++; if (bus.ap_done !== 1'b0) begin errs++; $display("FAIL post_rst_done c=%0d got %b want 0", c, bus.ap_done); end
      vecs++; if (bus.ap_idle !== 1'b1) begin errs++; $display("FAIL post_rst_idle c=%0d got %b want 1", c, bus.ap_idle); end
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_add();
    test_sub_sat();
    test_back_to_back();
    test_stall();
    test_ce();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
